// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t      : 32-bit data/address word.
//   ramstate_t  : state reported by the RAM model (FREE, BUSY, ACCESS, ERROR).
//   arb_state_t : request FSM state of mem_arbiter_rr. Enumerators are prefixed
//                 so they do not collide with ramstate_t BUSY in this package.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational search for the first set request bit at or after a
// pointer, wrapping modulo NREQ.
//   req_i   : request vector
//   ptr_i   : search start index
//   found_o : any request bit set
//   idx_o   : index of the selected request (0 when none found)
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int j;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = (int'(ptr_i) + k) % int'(NREQ);
      if (!found_o && req_i[j[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: shares one RAM port among NREQ cache requesters
// (index 2k = icache of CPU k, 2k+1 = dcache of CPU k).
// A request is latched in IDLE and issued to RAM from the following cycle (BUSY)
// until the RAM reports ACCESS (completion), ERROR, or the requester drops req.
//
// Build option: define MEMARB_FIXED_PRIO_EN for fixed priority (highest index
// wins, no round-robin pointer). Default build is round-robin.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   req_ren/req_wen      per-requester read/write request (write wins if both)
//   req_addr/req_store   per-requester address / write data, slice i at [i*WORD_W +: WORD_W]
//   req_wait             per-requester wait, low only in that requester's completion cycle
//   req_load             per-requester read data, held between completions
//   ramREN/ramWEN        RAM read/write enables
//   ramaddr/ramstore     RAM address / write data
//   ramload/ramstate     RAM read data / RAM state (ramstate_t)
//   arb_err              sticky RAM error flag, cleared only by reset
module mem_arbiter_rr
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_ren,
  input  logic [NREQ-1:0]        req_wen,
  input  logic [NREQ*WORD_W-1:0] req_addr,
  input  logic [NREQ*WORD_W-1:0] req_store,
  output logic [NREQ-1:0]        req_wait,
  output logic [NREQ*WORD_W-1:0] req_load,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic                   arb_err
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [WORD_W-1:0] addr_arr  [NREQ];
  logic [WORD_W-1:0] store_arr [NREQ];
  logic [WORD_W-1:0] load_out  [NREQ];
  logic [WORD_W-1:0] load_q    [NREQ];
  logic [WORD_W-1:0] load_d    [NREQ];

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic              wen_q, wen_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic              err_q, err_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  ramstate_t         rs;

  assign req     = req_ren | req_wen;
  assign rs      = ramstate_t'(ramstate);
  assign arb_err = err_q;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign addr_arr[gi]                   = req_addr[gi*WORD_W +: WORD_W];
    assign store_arr[gi]                  = req_store[gi*WORD_W +: WORD_W];
    assign req_load[gi*WORD_W +: WORD_W]  = load_out[gi];
  end

`ifdef MEMARB_FIXED_PRIO_EN
  // Reversing the vector and searching from 0 makes the highest index win.
  logic [NREQ-1:0]  req_rev;
  logic [IDX_W-1:0] rev_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rev
    assign req_rev[gi] = req[NREQ-1-gi];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i   (req_rev),
    .ptr_i   ({IDX_W{1'b0}}),
    .found_o (pick_found),
    .idx_o   (rev_idx)
  );

  assign pick_idx = IDX_W'(NREQ-1) - rev_idx;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Pointer moves past the served requester on completion or RAM error, not on abort.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ArbBusy && (rs == ACCESS || rs == ERROR)) begin
      ptr_d = (gnt_q == IDX_W'(NREQ-1)) ? '0 : gnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    err_d    = err_q;
    load_d   = load_q;
    load_out = load_q;
    req_wait = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      ArbIdle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          wen_d   = req_wen[pick_idx];
          addr_d  = addr_arr[pick_idx];
          store_d = store_arr[pick_idx];
          state_d = ArbBusy;
        end
      end
      ArbBusy: begin
        ramREN   = ~wen_q;
        ramWEN   = wen_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        // A RAM response in the same cycle as a dropped request still counts.
        if (rs == ACCESS) begin
          req_wait[gnt_q] = 1'b0;
          load_out[gnt_q] = ramload;
          load_d[gnt_q]   = ramload;
          state_d         = ArbIdle;
        end else if (rs == ERROR) begin
          err_d   = 1'b1;
          state_d = ArbIdle;
        end else if (!req[gnt_q]) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ArbIdle;
      gnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(NREQ); i++) load_q[i] <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed self-checking bench for mem_arbiter_rr (default round-robin build).
module tb_mem_arbiter_rr;
  import cpu_types_pkg::*;

  logic         CLK;
  logic         nRST;
  logic [3:0]   req_ren, req_wen;
  logic [127:0] req_addr, req_store;
  logic [3:0]   req_wait;
  logic [127:0] req_load;
  logic         ramREN, ramWEN;
  logic [31:0]  ramaddr, ramstore, ramload;
  logic [1:0]   ramstate;
  logic         arb_err;

  logic [31:0]  addr  [4];
  logic [31:0]  store [4];

  int n_cmp = 0;
  int n_err = 0;

  assign req_addr  = {addr[3], addr[2], addr[1], addr[0]};
  assign req_store = {store[3], store[2], store[1], store[0]};

  mem_arbiter_rr #(
    .NREQ   (4),
    .WORD_W (32)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_store (req_store),
    .req_wait  (req_wait),
    .req_load  (req_load),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .arb_err   (arb_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    nRST     = 1'b0;
    req_ren  = '0;
    req_wen  = '0;
    ramload  = '0;
    ramstate = FREE;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = '0;
      store[i] = '0;
    end

    // Reset state
    mid();
    chk("rst_ramREN",   ramREN,   1'b0);
    chk("rst_ramWEN",   ramWEN,   1'b0);
    chk("rst_ramaddr",  ramaddr,  32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_wait",     req_wait, 4'hF);
    chk("rst_load",     req_load, 128'h0);
    chk("rst_err",      arb_err,  1'b0);
    tick();
    tick();
    nRST = 1'b1;

    // Single read by requester 1, ACCESS on the third BUSY cycle
    req_ren = 4'b0010;
    addr[1] = 32'h40;
    mid();
    chk("rd_idle_ren", ramREN, 1'b0);
    tick();
    mid();
    chk("rd_busy_ren",  ramREN,  1'b1);
    chk("rd_busy_wen",  ramWEN,  1'b0);
    chk("rd_busy_addr", ramaddr, 32'h40);
    chk("rd_busy_wait", req_wait, 4'hF);
    tick();
    ramstate = BUSY;
    tick();
    ramstate = ACCESS;
    ramload  = 32'hDEADBEEF;
    mid();
    chk("rd_done_wait", req_wait, 4'b1101);
    chk("rd_done_load", req_load[63:32], 32'hDEADBEEF);
    tick();
    ramstate = FREE;
    ramload  = 32'h0;
    req_ren  = '0;
    mid();
    chk("rd_after_wait", req_wait, 4'hF);
    chk("rd_after_ren",  ramREN,   1'b0);
    chk("rd_after_hold", req_load[63:32], 32'hDEADBEEF);

    // Write wins over read on requester 2 (pointer now 2)
    req_ren  = 4'b0100;
    req_wen  = 4'b0100;
    addr[2]  = 32'h80;
    store[2] = 32'h12345678;
    tick();
    ramstate = ACCESS;
    mid();
    chk("wr_wen",   ramWEN,   1'b1);
    chk("wr_ren",   ramREN,   1'b0);
    chk("wr_store", ramstore, 32'h12345678);
    chk("wr_addr",  ramaddr,  32'h80);
    chk("wr_wait",  req_wait, 4'b1011);
    tick();
    ramstate = FREE;
    req_ren  = '0;
    req_wen  = '0;

    // RAM error on requester 3 (pointer now 3)
    for (int i = 0; i < 4; i++) addr[i] = 32'h1000 + 32'h100 * i;
    req_ren = 4'b1000;
    tick();
    ramstate = ERROR;
    mid();
    chk("err_addr",     ramaddr,  32'h1300);
    chk("err_wait",     req_wait, 4'hF);
    chk("err_not_yet",  arb_err,  1'b0);
    tick();
    ramstate = FREE;
    req_ren  = 4'b1111;

    // All requesters hold reads: grants 0,1,2,3 then wrap to 0
    for (int g = 0; g < 4; g++) begin
      mid();
      chk("rr_idle_ren", ramREN,  1'b0);
      chk("rr_err_stk",  arb_err, 1'b1);
      tick();
      ramstate = ACCESS;
      ramload  = 32'hA000_0000 + 32'(g);
      mid();
      chk("rr_grant", ramaddr,  32'(32'h1000 + 32'h100 * g));
      chk("rr_wait",  req_wait, 4'(~(4'b0001 << g)));
      tick();
      ramstate = FREE;
    end
    chk("rr_load3", req_load[127:96], 32'hA000_0003);

    // Wrapped grant to 0, then abort while RAM is BUSY
    tick();
    ramstate = BUSY;
    mid();
    chk("wrap_grant", ramaddr, 32'h1000);
    chk("wrap_err",   arb_err, 1'b1);
    req_ren = '0;
    tick();
    ramstate = FREE;
    mid();
    chk("abort_ren",  ramREN,   1'b0);
    chk("abort_wait", req_wait, 4'hF);
    // Pointer must still be 0: with 0 and 3 requesting, 0 wins
    req_ren = 4'b1001;
    tick();
    mid();
    chk("abort_ptr", ramaddr, 32'h1000);
    req_ren = '0;
    tick();

    // Outstanding write, then asynchronous reset between clock edges
    req_wen  = 4'b0010;
    addr[1]  = 32'h55;
    store[1] = 32'hCAFEF00D;
    tick();
    mid();
    chk("prerst_wen",  ramWEN,  1'b1);
    chk("prerst_addr", ramaddr, 32'h55);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_wen",  ramWEN,   1'b0);
    chk("arst_ren",  ramREN,   1'b0);
    chk("arst_addr", ramaddr,  32'h0);
    chk("arst_wait", req_wait, 4'hF);
    chk("arst_err",  arb_err,  1'b0);
    chk("arst_load", req_load, 128'h0);

    req_wen = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
